// File: rtl/hash_des_multi_channel.sv
// Multi-channel front-end: buffers CHANNELS byte-stream messages and time-shares
// one DES-box hash core between them in round-robin order.
module hash_des_multi_channel #(
  parameter  int CHANNELS = 4,
  parameter  int DEPTH    = 16,
  parameter  int TIMEOUT  = 64,
  localparam int CH_W     = $clog2(CHANNELS),
  localparam int LEN_W    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_chan,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_chan,
  output logic [LEN_W-1:0] out_len,
  output logic [31:0]      out_digest,
  output logic             err_valid,
  output logic [CH_W-1:0]  err_chan,
  output logic [1:0]       err_code
);
  localparam int DEP_W = $clog2(DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {FILL, PEND, BUSY} ch_st_t;
  typedef enum logic [1:0] {IDLE, FEED, WAIT, OUT} st_t;

  ch_st_t           ch_st [CHANNELS];
  logic [LEN_W-1:0] cnt   [CHANNELS];
  logic [7:0]       mem   [CHANNELS][DEPTH];
  logic [CHANNELS-1:0] ovf;

  st_t              st, nst;
  logic [CH_W-1:0]  rr, grant, pick, cidx, ovf_pch;
  logic [LEN_W-1:0] feed_idx, len;
  logic [TMO_W-1:0] wait_cnt;
  logic             any_pend, last_feed, ovf_pend;
  logic             m_valid, hash_ready;
  logic [7:0]       message;
  logic [31:0]      digest;
  logic             do_grant, do_latch, do_tmo, do_done;
  logic             acc, full, ovf_now, ovf_evt;

  assign in_ready  = (ch_st[in_chan] == FILL);
  assign acc       = in_valid & in_ready;
  assign full      = (cnt[in_chan] == LEN_W'(DEPTH));
  assign ovf_now   = ovf[in_chan] | (~in_empty & full);
  assign ovf_evt   = acc & in_last & ovf_now;
  assign len       = cnt[grant];
  assign last_feed = (len == '0) || (feed_idx == len - LEN_W'(1));

  // Downward scan so the PEND channel nearest the pointer is picked last and wins.
  always_comb begin
    pick = '0; any_pend = 1'b0; cidx = '0;
    for (int i = CHANNELS-1; i >= 0; i--) begin
      cidx = CH_W'((int'(rr) + i) % CHANNELS);
      if (ch_st[cidx] == PEND) begin any_pend = 1'b1; pick = cidx; end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= nst;
  end

  always_comb begin
    nst = st; m_valid = 1'b0; message = '0; out_valid = 1'b0;
    do_grant = 1'b0; do_latch = 1'b0; do_tmo = 1'b0; do_done = 1'b0;
    case (st)
      IDLE: if (any_pend) begin do_grant = 1'b1; nst = FEED; end
      FEED: begin
        m_valid = 1'b1;
        message = (len == '0) ? 8'h00 : mem[grant][feed_idx[DEP_W-1:0]];
        if (last_feed) nst = WAIT;
      end
      // wait_cnt==0 is the guard cycle where a stale hash_ready is ignored
      WAIT: if (wait_cnt != '0 && hash_ready) begin do_latch = 1'b1; nst = OUT; end
            else if (wait_cnt == TMO_W'(TIMEOUT)) begin do_tmo = 1'b1; nst = IDLE; end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin do_done = 1'b1; nst = IDLE; end
      end
      default: nst = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && acc && !in_empty && !full)
      mem[in_chan][cnt[in_chan][DEP_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr <= '0; grant <= '0; feed_idx <= '0; wait_cnt <= '0; ovf <= '0;
      out_chan <= '0; out_len <= '0; out_digest <= '0;
      err_valid <= 1'b0; err_chan <= '0; err_code <= '0;
      ovf_pend <= 1'b0; ovf_pch <= '0;
      for (int c = 0; c < CHANNELS; c++) begin ch_st[c] <= FILL; cnt[c] <= '0; end
    end else begin
      if (do_grant) begin
        grant <= pick; rr <= CH_W'((int'(pick) + 1) % CHANNELS);
        ch_st[pick] <= BUSY; feed_idx <= '0;
      end
      if (m_valid) feed_idx <= feed_idx + LEN_W'(1);
      wait_cnt <= (st == WAIT) ? wait_cnt + TMO_W'(1) : '0;
      if (do_latch) begin out_chan <= grant; out_len <= len; out_digest <= digest; end
      if (do_done || do_tmo) begin ch_st[grant] <= FILL; cnt[grant] <= '0; end
      if (acc) begin
        if (!in_empty && !full) cnt[in_chan] <= cnt[in_chan] + LEN_W'(1);
        if (!in_empty && full)  ovf[in_chan] <= 1'b1;
        if (in_last) begin
          if (ovf_now) begin cnt[in_chan] <= '0; ovf[in_chan] <= 1'b0; end
          else ch_st[in_chan] <= PEND;
        end
      end
      // Timeout owns the error port; a colliding overflow is held one cycle.
      err_valid <= 1'b0;
      if (do_tmo) begin
        err_valid <= 1'b1; err_chan <= grant; err_code <= 2'd2;
        if (ovf_evt) begin ovf_pend <= 1'b1; ovf_pch <= in_chan; end
      end else if (ovf_pend) begin
        err_valid <= 1'b1; err_chan <= ovf_pch; err_code <= 2'd1;
        ovf_pend <= ovf_evt; ovf_pch <= in_chan;
      end else if (ovf_evt) begin
        err_valid <= 1'b1; err_chan <= in_chan; err_code <= 2'd1;
      end
    end
  end

  full_hash_des_box u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_valid    (m_valid),
    .message    (message),
    .counter    ({{(64-LEN_W){1'b0}}, len}),
    .hash_ready (hash_ready),
    .digest_out (digest)
  );
endmodule

// DES-box hash core: S1-box byte mixing into a 32-bit state, length folded in
// at finalisation; hash_ready holds until the next message starts.
module full_hash_des_box (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic [7:0]  message,
  input  logic [63:0] counter,
  output logic        hash_ready,
  output logic [31:0] digest_out
);
  localparam logic [31:0] IV    = 32'h1BAB7BC4;
  localparam logic [31:0] LEN_K = 32'h58B6E8A4;
  localparam logic [3:0][63:0] S1 = {64'hD60AE3B5719428CF, 64'h05A379CFB26D8E14,
                                     64'h8359BC6A1D2E47F0, 64'h7095C6A38BF21D4E};
  logic [31:0] st, base, len_q;
  logic [1:0]  row, fin;
  logic [3:0]  col, sb;
  logic        absorb;

  always_comb begin
    row  = {message[5], message[0]};
    col  = message[4:1];
    sb   = S1[row][{col, 2'b00} +: 4];
    base = absorb ? st : IV;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= '0; len_q <= '0; fin <= '0; absorb <= 1'b0;
      hash_ready <= 1'b0; digest_out <= '0;
    end else if (m_valid) begin
      st <= {base[26:0], base[31:27]} ^ {sb, 20'h0, message};
      len_q <= counter[31:0] ^ counter[63:32];
      absorb <= 1'b1; fin <= '0; hash_ready <= 1'b0;
    end else if (absorb) begin
      if (fin == 2'd2) begin
        digest_out <= st ^ (len_q * LEN_K);
        hash_ready <= 1'b1; absorb <= 1'b0;
      end else fin <= fin + 2'd1;
    end
  end
endmodule

// File: doc/hash_des_multi_channel.md
Name: hash_des_multi_channel

Overview:
Multi-channel front-end for the DES-box hash core (full_hash_des_box). It buffers up to CHANNELS independent byte-stream messages and time-multiplexes one core instance between channels using round-robin arbitration. Each completed message is fed to the core and its digest is returned with a channel tag on a valid/ready output. It generalises the single-stream hash block to N channels with flow control, zero-length message support and overflow/timeout error reporting.

Parameters:
CHANNELS, 4, number of input channels (>=2); CH_W = $clog2(CHANNELS)
DEPTH, 16, max message bytes buffered per channel; LEN_W = $clog2(DEPTH+1)
TIMEOUT, 64, max cycles waiting for core hash_ready before abort

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_chan  in  CH_W  channel of the beat
in_data  in  8  message byte
in_last  in  1  final beat of message
in_empty  in  1  with in_last: beat carries no byte (zero-length message, or terminator after last byte)
out_valid  out  1  digest available
out_ready  in  1  consumer accepts digest
out_chan  out  CH_W  channel of the digest
out_len  out  LEN_W  message length in bytes
out_digest  out  32  digest
err_valid  out  1  one-cycle error pulse
err_chan  out  CH_W  channel in error
err_code  out  2  1 = overflow, 2 = core timeout

Behaviour:
- Reset (rst_n=0 at posedge): all channels FILL with count 0; core FSM IDLE; RR pointer 0; out_valid=0; err_valid=0; out_chan, out_len, out_digest = 0; core M_valid=0.
- Per-channel state: FILL -> PEND (on accepted in_last) -> BUSY (granted) -> FILL (digest handed off or aborted).
- in_ready is combinational: 1 iff channel in_chan is in FILL.
- An accepted beat with in_empty=0 writes in_data to buf[in_chan][count] and increments count. A beat with in_empty=1 writes nothing.
- Overflow: a byte beat arriving at count==DEPTH sets the channel's ovf flag, and the byte is dropped. On in_last with ovf=1, the message is discarded, count is cleared, and the channel returns to FILL. err_valid pulses the next cycle with err_code=1.
- Core FSM states: IDLE, FEED, WAIT, OUT.
- IDLE: if any channel is PEND, grant the first PEND channel at or after the RR pointer. Set the pointer to grant+1 mod CHANNELS, move the channel to BUSY, and go to FEED.
- FEED: drives M_valid=1 for max(len,1) consecutive cycles, with message=buf[i] (0 when len=0) and counter = len zero-extended to 64 bits, constant for the whole message. Then goes to WAIT.
- WAIT: M_valid=0. Ignores hash_ready for 1 guard cycle, then latches digest_out on the first cycle hash_ready=1 and goes to OUT. If hash_ready stays low for TIMEOUT cycles, pulses err_valid with err_code=2, frees the channel to FILL, and goes to IDLE.
- OUT: out_valid=1; out_chan, out_len and out_digest are held stable until out_ready=1. On the handshake cycle, the channel is cleared to FILL and the FSM returns to IDLE; the next grant is no earlier than the following cycle.
- No new core message starts while in OUT (single digest register).
- Simultaneous PEND on several channels: served strictly by RR order.
- Input to a channel in the same cycle it leaves BUSY: rejected (in_ready=0); accepted from the next cycle.
- If overflow and timeout errors fall in the same cycle, the timeout is reported and the overflow pulse is delayed one cycle.
- Reset mid-operation: the entire state is discarded and the core is re-reset via rst_n. No digest or error is emitted for in-flight messages.

Test Plan:
- Reset, then on ch0 send one beat with in_last=1, in_empty=1 -> out_valid with out_chan=0, out_len=0, out_digest=32'h956F7883.
- On ch2 send byte 8'h41 ("A") with in_last=1 -> out_chan=2, out_len=1, out_digest=32'h2dd99066.
- In the same cycle window, complete "A" on ch3 and an empty message on ch1 (RR pointer 0) -> ch1 digest 956F7883 first, then ch3 digest 2dd99066. Pointer advances to 2 and then 0.
- Hold out_ready=0 for 10 cycles after out_valid -> out_* stays stable, core M_valid stays 0, and beats to other FILL channels are still accepted. Release -> single handshake, then the next PEND channel is served.
- Send DEPTH+1 bytes plus in_last on ch0 -> err_valid pulses once with err_chan=0, err_code=1, and no out_valid. Then "A" on ch0 -> 2dd99066.
- Assert rst_n=0 during FEED of a ch1 message -> all outputs return to reset values with no digest emitted. Afterwards, an empty message on ch1 -> 956F7883.
